// File: rtl/hdlc_tx_frame_ctrl.sv
// hdlc_tx_frame_ctrl: HDLC transmit sequencer (flags, zero-bit insertion, abort pattern)
// All serial activity advances on tx_bit_en; buffer bytes arrive one cycle after rd_en_o.
module hdlc_tx_frame_ctrl #(
  parameter int MAX_LEN = 128
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_bit_en,
  input  logic       txen,
  input  logic       start_i,
  input  logic [7:0] frame_len_i,
  input  logic       abort_i,
  output logic       rd_en_o,
  input  logic [7:0] rd_data_i,
  output logic       tx,
  output logic       frame,
  output logic       abortframe,
  output logic       txdone,
  output logic       aborted_o,
  output logic       err_o,
  output logic       busy_o
);
  typedef enum logic [2:0] {IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT} state_t;
  localparam logic [7:0] FLAG = 8'h7E;
  localparam logic [7:0] ABT  = 8'h7F;
  localparam logic [7:0] MAX  = 8'(MAX_LEN);
  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [2:0] ones, ones_n, ones_inc;
  logic [7:0] left, left_n, hold;
  logic       cap, abort_pend, abort_n;
  logic       tx_n, frame_n, abortframe_n, txdone_n, aborted_n, err_n, rd_en_n;
  logic       data_bit, stuff, byte_end, in_frame, kill;
  assign busy_o = state != IDLE;
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    ones_n       = ones;
    left_n       = left;
    abort_n      = abort_pend;
    tx_n         = tx;
    frame_n      = frame;
    abortframe_n = abortframe;
    txdone_n     = 1'b0;
    aborted_n    = 1'b0;
    err_n        = 1'b0;
    rd_en_n      = 1'b0;
    data_bit     = hold[idx[2:0]];
    ones_inc     = data_bit ? ones + 3'd1 : 3'd0;
    stuff        = ones == 3'd5;
    // idx 8 marks "all data bits sent, stuff bit still owed"
    byte_end     = stuff ? idx == 4'd8 : (idx == 4'd7 && ones_inc != 3'd5);
    in_frame     = state inside {OPEN_FLAG, DATA, CLOSE_FLAG};
    kill         = in_frame && (abort_pend || !txen);
    if (in_frame && abort_i) abort_n = 1'b1;
    if (state == IDLE) begin
      if (start_i && txen) begin
        err_n   = frame_len_i == 8'd0 || frame_len_i > MAX;
        state_n = err_n ? IDLE : OPEN_FLAG;
        idx_n   = 4'd0;
        left_n  = err_n ? left : frame_len_i;
      end
    end else if (tx_bit_en) begin
      if (kill) begin
        state_n      = ABORT;
        idx_n        = 4'd1;
        tx_n         = ABT[0];
        frame_n      = 1'b0;
        abortframe_n = 1'b1;
        abort_n      = 1'b0;
      end else case (state)
        OPEN_FLAG: begin
          tx_n    = FLAG[idx[2:0]];
          frame_n = 1'b1;
          idx_n   = idx == 4'd7 ? 4'd0 : idx + 4'd1;
          rd_en_n = idx == 4'd7;
          state_n = idx == 4'd7 ? DATA : OPEN_FLAG;
          ones_n  = 3'd0;
        end
        DATA: begin
          tx_n   = stuff ? 1'b0 : data_bit;
          ones_n = stuff ? 3'd0 : ones_inc;
          idx_n  = stuff ? idx : idx + 4'd1;
          if (byte_end) begin
            idx_n   = 4'd0;
            state_n = left == 8'd1 ? CLOSE_FLAG : DATA;
            left_n  = left == 8'd1 ? left : left - 8'd1;
            rd_en_n = left != 8'd1;
          end
        end
        CLOSE_FLAG: begin
          tx_n     = idx == 4'd8 ? 1'b1 : FLAG[idx[2:0]];
          idx_n    = idx == 4'd8 ? 4'd0 : idx + 4'd1;
          frame_n  = idx != 4'd8;
          txdone_n = idx == 4'd8;
          state_n  = idx == 4'd8 ? IDLE : CLOSE_FLAG;
          abort_n  = idx == 4'd8 ? 1'b0 : abort_n;
        end
        default: begin
          tx_n         = idx == 4'd8 ? 1'b1 : ABT[idx[2:0]];
          idx_n        = idx == 4'd8 ? 4'd0 : idx + 4'd1;
          abortframe_n = idx != 4'd8;
          aborted_n    = idx == 4'd8;
          state_n      = idx == 4'd8 ? IDLE : ABORT;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      ones       <= '0;
      left       <= '0;
      hold       <= '0;
      cap        <= 1'b0;
      abort_pend <= 1'b0;
      tx         <= 1'b1;
      frame      <= 1'b0;
      abortframe <= 1'b0;
      txdone     <= 1'b0;
      aborted_o  <= 1'b0;
      err_o      <= 1'b0;
      rd_en_o    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      ones       <= ones_n;
      left       <= left_n;
      abort_pend <= abort_n;
      tx         <= tx_n;
      frame      <= frame_n;
      abortframe <= abortframe_n;
      txdone     <= txdone_n;
      aborted_o  <= aborted_n;
      err_o      <= err_n;
      rd_en_o    <= rd_en_n;
      cap        <= rd_en_o;
      if (cap) hold <= rd_data_i;
    end
  end
endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// tb_hdlc_tx_frame_ctrl: random frames against a bit-stream model; scoreboard checks every emitted bit
module tb_hdlc_tx_frame_ctrl;
  logic clk = 0, rst_i = 1, tx_bit_en = 0, txen = 1, start_i = 0, abort_i = 0;
  logic [7:0] frame_len_i = 0, rd_data_i = 0;
  logic rd_en_o, tx, frame, abortframe, txdone, aborted_o, err_o, busy_o;
  int chk = 0, errs = 0, rd_cnt = 0, done_cnt = 0, ab_cnt = 0, err_cnt = 0, bits_seen = 0;
  logic [2:0] exp_q[$];
  logic [7:0] buf_q[$], fixed_q[$];
  bit stream[$];
  int fetch_pos[$];

  hdlc_tx_frame_ctrl #(.MAX_LEN(128)) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_bit_en(tx_bit_en), .txen(txen), .start_i(start_i),
    .frame_len_i(frame_len_i), .abort_i(abort_i), .rd_en_o(rd_en_o), .rd_data_i(rd_data_i),
    .tx(tx), .frame(frame), .abortframe(abortframe), .txdone(txdone), .aborted_o(aborted_o),
    .err_o(err_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    chk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Expected line bits for a complete frame, plus the bit count after which each byte is fetched
  function automatic void build(input logic [7:0] b[$]);
    logic [7:0] f = 8'h7E;
    int ones = 0;
    stream.delete();
    fetch_pos.delete();
    for (int i = 0; i < 8; i++) stream.push_back(f[i]);
    fetch_pos.push_back(8);
    for (int j = 0; j < b.size(); j++) begin
      for (int i = 0; i < 8; i++) begin
        stream.push_back(b[j][i]);
        ones = b[j][i] ? ones + 1 : 0;
        if (ones == 5) begin
          stream.push_back(1'b0);
          ones = 0;
        end
      end
      if (j < b.size() - 1) fetch_pos.push_back(stream.size());
    end
    for (int i = 0; i < 8; i++) stream.push_back(f[i]);
  endfunction

  initial forever begin
    repeat ($urandom_range(2, 4)) @(negedge clk);
    tx_bit_en = 1;
    @(negedge clk);
    tx_bit_en = 0;
  end

  initial forever begin
    @(negedge clk);
    if (rd_en_o) rd_data_i = buf_q.size() > 0 ? buf_q.pop_front() : 8'h00;
  end

  always @(posedge clk) begin
    if (rd_en_o) rd_cnt++;
    if (txdone) done_cnt++;
    if (aborted_o) ab_cnt++;
    if (err_o) err_cnt++;
  end

  initial forever begin
    @(posedge clk);
    if (tx_bit_en && !rst_i) begin
      #1;
      if (frame || abortframe) begin
        bits_seen++;
        if (exp_q.size() == 0) begin
          chk++;
          errs++;
          $display("FAIL extra_bit got tx=%0d frame=%0d abortframe=%0d expected none", tx, frame, abortframe);
        end else check("bit{tx,frame,abortframe}", int'({tx, frame, abortframe}), int'(exp_q.pop_front()));
      end
    end
  end

  // kind: 0 normal (+start while busy), 1 abort_i, 2 txen drop, 3 reset, 4 start with abort_i
  task automatic do_frame(input int len, input int kind, input int k);
    logic [7:0] b[$];
    int exp_rd, rd0, d0, a0, s0, n;
    bit ok, ab;
    ab = kind == 1 || kind == 2;
    for (int i = 0; i < len; i++)
      b.push_back(i < fixed_q.size() ? fixed_q[i] : ($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom)));
    fixed_q.delete();
    build(b);
    n = (ab || kind == 3) ? k : stream.size();
    for (int i = 0; i < n; i++) exp_q.push_back({stream[i], 2'b10});
    if (ab) for (int i = 0; i < 8; i++) exp_q.push_back(i < 7 ? 3'b101 : 3'b001);
    exp_rd = ab ? 0 : len;
    if (ab) foreach (fetch_pos[i]) if (fetch_pos[i] <= k) exp_rd++;
    buf_q = b;
    rd0 = rd_cnt; d0 = done_cnt; a0 = ab_cnt; s0 = bits_seen;
    @(negedge clk);
    start_i = 1; frame_len_i = 8'(len); abort_i = kind == 4;
    @(negedge clk);
    start_i = 0; abort_i = 0;
    ok = 0;
    for (int t = 0; t < 20000; t++) begin
      if (bits_seen - s0 >= k) begin ok = 1; break; end
      @(negedge clk);
    end
    check("reach_bit", int'(ok), 1);
    case (kind)
      0: begin start_i = 1; frame_len_i = 8'd3; @(negedge clk); start_i = 0; end
      1: begin abort_i = 1; @(negedge clk); abort_i = 0; end
      2: txen = 0;
      3: begin
        rst_i = 1;
        #1;
        check("rst_outputs{tx,frame,abortframe,busy}", int'({tx, frame, abortframe, busy_o}), 8);
        @(negedge clk);
        rst_i = 0;
        exp_q.delete();
        buf_q.delete();
        repeat (20) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle_tx", int'(tx), 1);
        return;
      end
      default: ;
    endcase
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (done_cnt != d0 || ab_cnt != a0) break;
    end
    @(negedge clk);
    check("txdone_pulses", done_cnt - d0, ab ? 0 : 1);
    check("aborted_pulses", ab_cnt - a0, ab ? 1 : 0);
    check("rd_en_pulses", rd_cnt - rd0, exp_rd);
    check("bits_left", exp_q.size(), 0);
    check("idle_tx", int'(tx), 1);
    check("idle_busy", int'(busy_o), 0);
    txen = 1;
    exp_q.delete();
    buf_q.delete();
  endtask

  task automatic do_err(input int len, input bit en);
    int e0, r0;
    e0 = err_cnt; r0 = rd_cnt;
    txen = en;
    @(negedge clk);
    start_i = 1; frame_len_i = 8'(len);
    @(negedge clk);
    start_i = 0;
    check("busy_after_bad_start", int'(busy_o), 0);
    repeat (3) @(negedge clk);
    check("err_pulses", err_cnt - e0, (en && (len == 0 || len > 128)) ? 1 : 0);
    check("err_rd_en", rd_cnt - r0, 0);
    check("err_tx", int'(tx), 1);
    txen = 1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({tx, frame, abortframe, txdone, aborted_o, err_o, rd_en_o, busy_o}), 8'h80);
    rst_i = 0;
    repeat (5) @(negedge clk);
    fixed_q.push_back(8'h01);
    do_frame(1, 0, 10);
    fixed_q.push_back(8'hFF); fixed_q.push_back(8'hFF);
    do_frame(2, 0, 10);
    fixed_q.push_back(8'h1F);
    do_frame(1, 0, 10);
    do_frame(4, 1, 22);
    do_err(0, 1);
    do_err(200, 1);
    do_err(129, 1);
    do_err(5, 0);
    do_frame(3, 2, 20);
    do_frame(3, 3, 20);
    do_frame(2, 4, 0);
    do_frame(128, 0, 10);
    for (int r = 0; r < 10; r++) begin
      int len, kind;
      len = $urandom_range(1, 8);
      kind = $urandom_range(0, 2);
      do_frame(len, kind, kind == 0 ? 10 : $urandom_range(1, 8 + 8 * len));
    end
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule

// File: doc/hdlc_tx_frame_ctrl.md
Name: hdlc_tx_frame_ctrl

Overview:
- Transmit-side sequencer for the HDLC serial line.
- On a start request it emits an opening flag, then fetches frame_len_i bytes from the Tx byte buffer and shifts them out LSB-first with zero-bit insertion, then emits a closing flag.
- On an abort request, or when txen falls mid-frame, it emits the abort pattern instead of completing the frame.
- All bit-level actions advance only on the tx_bit_en strobe. The block drives tx, frame, abortframe and txdone.

Parameters:
- MAX_LEN, 128, maximum accepted frame length in bytes (1..255).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- tx_bit_en  in  1  bit-rate strobe, one clk_i cycle wide; minimum spacing 3 clk_i cycles
- txen  in  1  transmitter enable
- start_i  in  1  one-cycle pulse, request frame transmission
- frame_len_i  in  8  data byte count, sampled on accepted start_i
- abort_i  in  1  one-cycle pulse, request abort
- rd_en_o  out  1  one-cycle pop request to Tx byte buffer
- rd_data_i  in  8  buffer byte, valid the clk_i cycle after rd_en_o
- tx  out  1  serial output
- frame  out  1  frame in progress
- abortframe  out  1  abort pattern in progress
- txdone  out  1  one-cycle pulse, frame completed normally
- aborted_o  out  1  one-cycle pulse, abort pattern completed
- err_o  out  1  one-cycle pulse, start rejected
- busy_o  out  1  state != IDLE

Behaviour:
- Interface: one clock clk_i; rst_i asynchronous, active-high.
- Reset values:
  - tx=1.
  - frame, abortframe, txdone, aborted_o, err_o, rd_en_o and busy_o all 0.
  - State IDLE; all counters 0.
  - Reset asserted mid-frame forces these values immediately, with no flag or abort emitted.
- tx timing: tx is registered and changes only on clk_i edges where tx_bit_en=1. "Strobe" below means such an edge.
- States: IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT.
- IDLE:
  - tx held 1.
  - start_i with txen=1 and 1<=frame_len_i<=MAX_LEN: latch length, go to OPEN_FLAG.
  - start_i with length 0 or >MAX_LEN: pulse err_o next cycle, stay IDLE.
  - start_i with txen=0 is ignored. start_i while busy is ignored.
- OPEN_FLAG:
  - Emits 0x7E LSB-first (0,1,1,1,1,1,1,0) on 8 successive strobes.
  - frame goes 1 on the strobe emitting bit 0.
  - rd_en_o pulses on the clk_i cycle after the strobe emitting flag bit 7; the byte is captured into the holding register on the following cycle.
  - Next state DATA.
- DATA:
  - Shifts the holding byte LSB-first, one bit per strobe.
  - Ones counter (3 bits):
    - cleared on entering DATA;
    - increments on each transmitted data 1;
    - cleared on any transmitted 0.
  - Zero insertion: when the counter reaches 5, the next strobe emits a stuffed 0 instead of the next data bit and clears the counter. The data bit index does not advance. Stuffing applies across byte boundaries and after the final data bit.
  - Flags and abort pattern are never stuffed.
  - After bit 7 of a non-final byte is emitted, and any pending stuff bit has been emitted: rd_en_o pulses and the next byte is loaded before the next strobe.
  - Exactly frame_len_i rd_en_o pulses per completed frame.
  - After the final byte and any pending stuff bit, go to CLOSE_FLAG.
- CLOSE_FLAG:
  - Emits 0x7E LSB-first.
  - On the strobe after bit 7, frame falls, txdone pulses one clk_i cycle, and the state returns to IDLE (tx=1).
- Abort handling:
  - abort_i in OPEN_FLAG, DATA or CLOSE_FLAG is latched.
  - txen=0 in those states is treated as an abort.
  - At the next strobe the state goes to ABORT: the current byte is discarded, and no further rd_en_o is issued.
  - abort_i in IDLE or ABORT is ignored.
- ABORT:
  - frame=0; abortframe=1 from the first abort bit through the last.
  - Emits 1,1,1,1,1,1,1,0 on 8 strobes.
  - Then abortframe=0, aborted_o pulses, state returns to IDLE.
  - txdone is not pulsed.
- Simultaneous events:
  - start_i and abort_i in the same IDLE cycle: start is accepted and abort is ignored.
  - abort_i on the same cycle as the final closing-flag strobe: the frame completes (txdone) and the abort is dropped.

Test Plan:
- len=1, byte 0x01 -> tx = 0,1,1,1,1,1,1,0 / 1,0,0,0,0,0,0,0 / 0,1,1,1,1,1,1,0; exactly one rd_en_o pulse; frame high for 24 strobes; one txdone pulse; tx=1 afterwards.
- len=2, bytes 0xFF,0xFF -> data bits 1,1,1,1,1,0,1,1,1 then 1,1,0,1,1,1,1,1,0,1 (19 bits); then closing flag; txdone pulse.
- len=1, byte 0x1F -> data 1,1,1,1,1,0,0,0,0; the stuffed 0 precedes the remaining three zeros.
- len=4, abort_i during byte 2 -> from the next strobe tx = 1,1,1,1,1,1,1,0; abortframe high for 8 strobes; aborted_o pulses once; only 2 rd_en_o pulses total; no txdone.
- start_i with frame_len_i=0, then with 200 -> err_o pulses each time; tx stays 1; no rd_en_o; busy_o stays 0.
- txen dropped mid-DATA -> abort sequence as above. Separately, rst_i mid-DATA -> tx=1 and frame=0 in the same cycle; start_i while busy -> ignored, no second frame.
